// File: rtl/clkdiv_ctrl.sv
// Runtime-programmable clock divider: period/high-time config applied on period
// boundaries, start/stop sequencing and N-period bursts.
module clkdiv_ctrl #(
    parameter int unsigned W          = 16,
    parameter int unsigned C          = 16,
    parameter int unsigned DEF_PERIOD = 500,
    parameter int unsigned DEF_HIGH   = 250
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cfg_valid,
    output logic         cfg_ready,
    input  logic [W-1:0] cfg_period,
    input  logic [W-1:0] cfg_high,
    input  logic [C-1:0] cfg_count,
    output logic         cfg_err,
    input  logic         start,
    input  logic         stop,
    output logic         nclk,
    output logic         tick,
    output logic         busy,
    output logic         done,
    output logic [C-1:0] pulses_left
);

    // Config handshake: a transfer happens on any edge where cfg_valid & cfg_ready;
    // cfg_ready drops while a validated config waits in the pending register.

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t       state;
    logic [W-1:0] cnt;
    logic [W-1:0] act_period;
    logic [W-1:0] act_high;
    logic [C-1:0] act_count;
    logic         pend_valid;
    logic [W-1:0] pend_period;
    logic [W-1:0] pend_high;
    logic [C-1:0] pend_count;

    logic xfer;
    logic cfg_ok;
    logic at_end;
    logic burst_last;

    assign cfg_ready  = !pend_valid;
    assign busy       = (state != IDLE);
    assign xfer       = cfg_valid && !pend_valid;
    assign cfg_ok     = (cfg_period >= W'(2)) && (cfg_high != '0) && (cfg_high < cfg_period);
    assign at_end     = (cnt == act_period - W'(1));
    assign burst_last = (act_count != '0) && (pulses_left == C'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            nclk        <= 1'b0;
            tick        <= 1'b0;
            done        <= 1'b0;
            cfg_err     <= 1'b0;
            pulses_left <= '0;
            act_period  <= W'(DEF_PERIOD);
            act_high    <= W'(DEF_HIGH);
            act_count   <= '0;
            pend_valid  <= 1'b0;
            pend_period <= '0;
            pend_high   <= '0;
            pend_count  <= '0;
        end else begin
            tick    <= 1'b0;
            done    <= 1'b0;
            cfg_err <= xfer && !cfg_ok;

            // A transfer only happens with pend_valid low, so it never collides with an apply below.
            if (xfer && cfg_ok) begin
                pend_valid  <= 1'b1;
                pend_period <= cfg_period;
                pend_high   <= cfg_high;
                pend_count  <= cfg_count;
            end

            case (state)
                IDLE: begin
                    cnt         <= '0;
                    nclk        <= 1'b0;
                    pulses_left <= '0;
                    if (pend_valid) begin
                        act_period <= pend_period;
                        act_high   <= pend_high;
                        act_count  <= pend_count;
                        pend_valid <= 1'b0;
                    end
                    // A start coinciding with an apply launches with the newly applied config.
                    if (start && !stop) begin
                        state       <= RUN;
                        nclk        <= 1'b1;
                        tick        <= 1'b1;
                        pulses_left <= pend_valid ? pend_count : act_count;
                    end
                end

                RUN, DRAIN: begin
                    if (!at_end) begin
                        cnt  <= cnt + W'(1);
                        nclk <= (cnt + W'(1)) < act_high;
                        if (state == RUN && stop) begin
                            state <= DRAIN;
                        end
                    end else if (state == DRAIN || burst_last) begin
                        state       <= IDLE;
                        cnt         <= '0;
                        nclk        <= 1'b0;
                        done        <= 1'b1;
                        pulses_left <= '0;
                    end else begin
                        cnt  <= '0;
                        nclk <= 1'b1;
                        tick <= 1'b1;
                        // A newly applied config starts its own burst from this period.
                        if (pend_valid) begin
                            act_period  <= pend_period;
                            act_high    <= pend_high;
                            act_count   <= pend_count;
                            pend_valid  <= 1'b0;
                            pulses_left <= pend_count;
                        end else if (act_count != '0) begin
                            pulses_left <= pulses_left - C'(1);
                        end
                        if (state == RUN && stop) begin
                            state <= DRAIN;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
